// File: rtl/ball_pkg.sv
// Shared types and helpers for the ball kinematics engine: FSM encoding,
// default fixed-point widths and the velocity/position limiting functions.
package ball_pkg;

  localparam int COORD_W_DEF = 8;
  localparam int FRAC_W_DEF  = 4;
  localparam int VEL_W_DEF   = 8;
  localparam int ACCEL_W     = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_QX,
    ST_QY,
    ST_COMMIT
  } ball_state_e;

  function automatic int sat_vel(input int v, input int vmax);
    if (v > vmax) return vmax;
    if (v < -vmax) return -vmax;
    return v;
  endfunction

  function automatic int clamp_pos(input int c, input int hi);
    if (c < 0) return 0;
    if (c > hi) return hi;
    return c;
  endfunction

endpackage

// File: rtl/ball_axis_integrator.sv
// One axis of ball motion: dead-zone friction, velocity integration with
// saturation, and candidate position clamped to the arena, registered on calc_en.
module ball_axis_integrator
  import ball_pkg::*;
#(
  parameter int COORD_W     = COORD_W_DEF,
  parameter int FRAC_W      = FRAC_W_DEF,
  parameter int VEL_W       = VEL_W_DEF,
  parameter int ACCEL_SHIFT = 4,
  parameter int DEADZONE    = 16,
  parameter int VMAX        = 64,
  parameter int MAX_COORD   = 159
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      calc_en,
  input  logic                      zero_vel,
  input  logic [ACCEL_W-1:0]        accel,
  input  logic [COORD_W+FRAC_W-1:0] pos,
  output logic [COORD_W+FRAC_W-1:0] cand
);

  localparam int POS_W  = COORD_W + FRAC_W;
  localparam int POS_HI = MAX_COORD * (2 ** FRAC_W);

  logic signed [VEL_W-1:0] vel_q, vel_d;
  logic [POS_W-1:0]        cand_q, cand_d;
  int                      acc_i, v_i, c_i;

  always_comb begin
    vel_d  = vel_q;
    cand_d = cand_q;
    acc_i  = int'($signed(accel));
    v_i    = int'(vel_q);
    if (acc_i < DEADZONE && acc_i > -DEADZONE) begin
      if (v_i > 0) v_i = v_i - 1;
      else if (v_i < 0) v_i = v_i + 1;
    end else begin
      v_i = v_i + (acc_i >>> ACCEL_SHIFT);
    end
    v_i = sat_vel(v_i, VMAX);
    c_i = int'(pos) + v_i;
    // Hitting the arena edge kills momentum on this axis
    if (c_i < 0 || c_i > POS_HI) v_i = 0;
    c_i = clamp_pos(c_i, POS_HI);
    if (calc_en) begin
      vel_d  = VEL_W'(v_i);
      cand_d = POS_W'(c_i);
    end else if (zero_vel) begin
      vel_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vel_q  <= '0;
      cand_q <= '0;
    end else begin
      vel_q  <= vel_d;
      cand_q <= cand_d;
    end
  end

  assign cand = cand_q;

endmodule

// File: rtl/ball_motion_ctrl.sv
// Labyrinth ball kinematics top: tick divider, per-tick FSM that integrates
// both axes, checks each moved axis against the maze map, and commits position.
module ball_motion_ctrl
  import ball_pkg::*;
#(
  parameter int CLK_FREQUENCY_HZ       = 100000000,
  parameter int UPDATE_FREQUENCY_HZ    = 50,
  parameter int COORD_W                = COORD_W_DEF,
  parameter int FRAC_W                 = FRAC_W_DEF,
  parameter int VEL_W                  = VEL_W_DEF,
  parameter int ACCEL_SHIFT            = 4,
  parameter int DEADZONE               = 16,
  parameter int VMAX                   = 64,
  parameter int X_MAX                  = 159,
  parameter int Y_MAX                  = 119,
  parameter int SIMULATE               = 0,
  parameter int SIMULATE_FREQUENCY_CNT = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [8:0]         accelX_IN,
  input  logic [8:0]         accelY_IN,
  output logic               map_req,
  output logic [COORD_W-1:0] map_x,
  output logic [COORD_W-1:0] map_y,
  input  logic               map_ack,
  input  logic               map_wall,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               busy,
  output logic               tick_overrun
);

  localparam int POS_W   = COORD_W + FRAC_W;
  localparam int TOP_CNT = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                           : (CLK_FREQUENCY_HZ / UPDATE_FREQUENCY_HZ) - 1;
  localparam logic [31:0] DIV_TOP = 32'(TOP_CNT);

  ball_state_e        state_q, state_d;
  logic [31:0]        div_cnt_q, div_cnt_d;
  logic [POS_W-1:0]   pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [COORD_W-1:0] x_out_q, x_out_d, y_out_q, y_out_d;
  logic               overrun_q, overrun_d;
  logic               tick, calc_en, zero_vx, zero_vy;
  logic [POS_W-1:0]   cand_x, cand_y;
  logic [COORD_W-1:0] cand_x_int, cand_y_int;

  ball_axis_integrator #(
    .COORD_W(COORD_W), .FRAC_W(FRAC_W), .VEL_W(VEL_W), .ACCEL_SHIFT(ACCEL_SHIFT),
    .DEADZONE(DEADZONE), .VMAX(VMAX), .MAX_COORD(X_MAX)
  ) u_axis_x (
    .clk(clk), .rst(reset), .calc_en(calc_en), .zero_vel(zero_vx),
    .accel(accelX_IN), .pos(pos_x_q), .cand(cand_x)
  );

  ball_axis_integrator #(
    .COORD_W(COORD_W), .FRAC_W(FRAC_W), .VEL_W(VEL_W), .ACCEL_SHIFT(ACCEL_SHIFT),
    .DEADZONE(DEADZONE), .VMAX(VMAX), .MAX_COORD(Y_MAX)
  ) u_axis_y (
    .clk(clk), .rst(reset), .calc_en(calc_en), .zero_vel(zero_vy),
    .accel(accelY_IN), .pos(pos_y_q), .cand(cand_y)
  );

  assign tick       = (div_cnt_q == DIV_TOP);
  assign cand_x_int = cand_x[POS_W-1:FRAC_W];
  assign cand_y_int = cand_y[POS_W-1:FRAC_W];

  always_comb begin
    state_d   = state_q;
    div_cnt_d = tick ? '0 : div_cnt_q + 32'd1;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    x_out_d   = x_out_q;
    y_out_d   = y_out_q;
    overrun_d = overrun_q | (tick && state_q != ST_IDLE);
    calc_en   = 1'b0;
    zero_vx   = 1'b0;
    zero_vy   = 1'b0;
    map_req   = 1'b0;
    map_x     = x_out_q;
    map_y     = y_out_q;
    case (state_q)
      ST_IDLE: if (tick) state_d = ST_CALC;
      ST_CALC: begin
        calc_en = 1'b1;
        state_d = ST_QX;
      end
      ST_QX: begin
        if (cand_x_int == x_out_q) begin
          pos_x_d = cand_x;
          state_d = ST_QY;
        end else begin
          map_req = 1'b1;
          map_x   = cand_x_int;
          if (map_ack) begin
            if (map_wall) zero_vx = 1'b1;
            else pos_x_d = cand_x;
            state_d = ST_QY;
          end
        end
      end
      // Y is checked against the already-resolved X so the ball slides along walls
      ST_QY: begin
        if (cand_y_int == y_out_q) begin
          pos_y_d = cand_y;
          state_d = ST_COMMIT;
        end else begin
          map_req = 1'b1;
          map_x   = pos_x_q[POS_W-1:FRAC_W];
          map_y   = cand_y_int;
          if (map_ack) begin
            if (map_wall) zero_vy = 1'b1;
            else pos_y_d = cand_y;
            state_d = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        x_out_d = pos_x_q[POS_W-1:FRAC_W];
        y_out_d = pos_y_q[POS_W-1:FRAC_W];
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= '0;
      pos_x_q   <= '0;
      pos_y_q   <= '0;
      x_out_q   <= '0;
      y_out_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      x_out_q   <= x_out_d;
      y_out_q   <= y_out_d;
      overrun_q <= overrun_d;
    end
  end

  assign x_out        = x_out_q;
  assign y_out        = y_out_q;
  assign busy         = (state_q != ST_IDLE);
  assign tick_overrun = overrun_q;

endmodule
